// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter sharing one downstream memory port among up to four
//   upstream requesters. Each issued request is tagged with the requester
//   index on mem_id_o; returning read data is steered back by mem_rid_i.
//   Per-port counters of outstanding read words throttle a port whose next
//   read would exceed MAX_OUTSTANDING_WORDS.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_*_i / req_*_o   upstream side, one slice per port (request held until ack)
//   mem_*_o / mem_*_i   downstream side (request/ack, id/rid tagged)
module mem_port_arbiter #(
  parameter int NUM_PORTS             = 4,
  parameter int MAX_OUTSTANDING_WORDS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_request_i,
  input  logic [NUM_PORTS*30-1:0] req_addr_i,
  input  logic [NUM_PORTS*5-1:0]  req_rlen_i,
  input  logic [NUM_PORTS-1:0]    req_rnw_i,
  input  logic [NUM_PORTS-1:0]    req_rmw_i,
  input  logic [NUM_PORTS*4-1:0]  req_wbe_i,
  input  logic [NUM_PORTS*32-1:0] req_wdata_i,
  output logic [NUM_PORTS-1:0]    req_ack_o,
  output logic [NUM_PORTS-1:0]    req_rvalid_o,
  output logic [31:0]             req_rdata_o,
  output logic                    mem_request_o,
  output logic [29:0]             mem_addr_o,
  output logic [4:0]              mem_rlen_o,
  output logic                    mem_rnw_o,
  output logic                    mem_rmw_o,
  output logic [3:0]              mem_wbe_o,
  output logic [31:0]             mem_wdata_o,
  output logic [1:0]              mem_id_o,
  input  logic                    mem_ack_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i,
  input  logic [1:0]              mem_rid_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING_WORDS + 1);
  // Two extra bits hold outstanding + rlen + 1 without overflow.
  localparam int SW = CW + 2;
  localparam logic [1:0] LAST_RESET = 2'(NUM_PORTS - 1);

  typedef enum logic {ARB, LOCKED} state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  locked_grant_q, locked_grant_d;
  logic [CW-1:0] outstanding_q [NUM_PORTS];
  logic [CW-1:0] outstanding_d [NUM_PORTS];

  // Per-port fields unpacked into four-entry arrays; unused entries read as
  // zero so the 2-bit grant can index them for any NUM_PORTS.
  logic [29:0] addr_a  [4];
  logic [4:0]  rlen_a  [4];
  logic        rnw_a   [4];
  logic        rmw_a   [4];
  logic [3:0]  wbe_a   [4];
  logic [31:0] wdata_a [4];
  logic [3:0]  elig;
  logic [1:0]  arb_grant;
  logic        arb_found;
  logic [1:0]  grant;
  logic        mem_req;
  logic        accept;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      addr_a[p]  = '0;
      rlen_a[p]  = '0;
      rnw_a[p]   = 1'b0;
      rmw_a[p]   = 1'b0;
      wbe_a[p]   = '0;
      wdata_a[p] = '0;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_a[p]  = req_addr_i[p*30 +: 30];
      rlen_a[p]  = req_rlen_i[p*5 +: 5];
      rnw_a[p]   = req_rnw_i[p];
      rmw_a[p]   = req_rmw_i[p];
      wbe_a[p]   = req_wbe_i[p*4 +: 4];
      wdata_a[p] = req_wdata_i[p*32 +: 32];
    end
  end

  // A read or rmw is held back when its words would push the port's
  // outstanding count past the ceiling; plain writes always pass.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig[p] = req_request_i[p] &
                ~((rnw_a[p] | rmw_a[p]) &
                  ((SW'(outstanding_q[p]) + SW'(rlen_a[p]) + SW'(1)) >
                   SW'(MAX_OUTSTANDING_WORDS)));
    end
  end

  // Round-robin search starting just above the last granted port.
  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!arb_found && elig[2'((int'(last_grant_q) + k) % NUM_PORTS)]) begin
        arb_grant = 2'((int'(last_grant_q) + k) % NUM_PORTS);
        arb_found = 1'b1;
      end
    end
  end

  // Once a request is presented without ack the grant is frozen until the
  // downstream accepts it, so fields never change under a pending request.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    locked_grant_d = locked_grant_q;
    grant          = arb_grant;
    mem_req        = |elig;
    case (state_q)
      ARB: begin
        if (mem_req) begin
          if (mem_ack_i) begin
            last_grant_d = arb_grant;
          end else begin
            locked_grant_d = arb_grant;
            state_d        = LOCKED;
          end
        end
      end
      LOCKED: begin
        grant   = locked_grant_q;
        mem_req = 1'b1;
        if (mem_ack_i) begin
          last_grant_d = locked_grant_q;
          state_d      = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign accept = mem_req & mem_ack_i;

  // Reads add their word count on acceptance; each returned word removes
  // one. A return with nothing outstanding is ignored rather than wrapping.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      outstanding_d[p] = outstanding_q[p];
      if (accept && (grant == 2'(p)) && (rnw_a[p] | rmw_a[p])) begin
        outstanding_d[p] = outstanding_d[p] + CW'(rlen_a[p]) + CW'(1);
      end
      if (mem_rvalid_i && (mem_rid_i == 2'(p)) && (outstanding_q[p] != '0)) begin
        outstanding_d[p] = outstanding_d[p] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB;
      last_grant_q   <= LAST_RESET;
      locked_grant_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        outstanding_q[p] <= '0;
      end
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      locked_grant_q <= locked_grant_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        outstanding_q[p] <= outstanding_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ack_o[p]    = accept & (grant == 2'(p));
      req_rvalid_o[p] = mem_rvalid_i & (mem_rid_i == 2'(p));
    end
  end

  // With no request the grant is 0, so port 0's fields keep the bus defined.
  assign mem_request_o = mem_req;
  assign mem_id_o      = grant;
  assign mem_addr_o    = addr_a[grant];
  assign mem_rlen_o    = rlen_a[grant];
  assign mem_rnw_o     = rnw_a[grant];
  assign mem_rmw_o     = rmw_a[grant];
  assign mem_wbe_o     = wbe_a[grant];
  assign mem_wdata_o   = wdata_a[grant];
  assign req_rdata_o   = mem_rdata_i;

  // Simulation checks: returning data for a port with nothing outstanding,
  // or for a port index that does not exist.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(mem_rvalid_i && (mem_rid_i == 2'(p)) && (outstanding_q[p] == '0)));
  end

  a_rid_in_range: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid_i && (int'(mem_rid_i) >= NUM_PORTS)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (NUM_PORTS = 4, ceiling 32).
//   Arbitration is exercised from a table of single-cycle vectors; the lock,
//   throttle, same-cycle counter and reset cases are hand-written sequences.
//   Returned read data is checked through a queue of expected responses.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_request;
  logic [119:0] req_addr;
  logic [19:0]  req_rlen;
  logic [3:0]   req_rnw;
  logic [3:0]   req_rmw;
  logic [15:0]  req_wbe;
  logic [127:0] req_wdata;
  logic [3:0]   req_ack;
  logic [3:0]   req_rvalid;
  logic [31:0]  req_rdata;
  logic         mem_request;
  logic [29:0]  mem_addr;
  logic [4:0]   mem_rlen;
  logic         mem_rnw;
  logic         mem_rmw;
  logic [3:0]   mem_wbe;
  logic [31:0]  mem_wdata;
  logic [1:0]   mem_id;
  logic         mem_ack;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic [1:0]   mem_rid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       expReq;
    logic [3:0] expAck;
    logic [1:0] expId;
  } vec_t;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
  } resp_t;

  resp_t sbQ[$];
  resp_t sbHead;
  vec_t  tbl [11];

  mem_port_arbiter #(.NUM_PORTS(4), .MAX_OUTSTANDING_WORDS(32)) dut (
    .clk(clk),
    .rst(rst),
    .req_request_i(req_request),
    .req_addr_i(req_addr),
    .req_rlen_i(req_rlen),
    .req_rnw_i(req_rnw),
    .req_rmw_i(req_rmw),
    .req_wbe_i(req_wbe),
    .req_wdata_i(req_wdata),
    .req_ack_o(req_ack),
    .req_rvalid_o(req_rvalid),
    .req_rdata_o(req_rdata),
    .mem_request_o(mem_request),
    .mem_addr_o(mem_addr),
    .mem_rlen_o(mem_rlen),
    .mem_rnw_o(mem_rnw),
    .mem_rmw_o(mem_rmw),
    .mem_wbe_o(mem_wbe),
    .mem_wdata_o(mem_wdata),
    .mem_id_o(mem_id),
    .mem_ack_i(mem_ack),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata),
    .mem_rid_i(mem_rid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    req_request = v.req;
    mem_ack     = v.ack;
  endtask

  // Drive one vector, compare at the falling edge, then advance one cycle.
  task automatic runVec(input vec_t v, input string tag);
    int id;
    applyStimulus(v);
    @(negedge clk);
    id = int'(v.expId);
    checkOutput({tag, ".mem_request"}, 32'(mem_request), 32'(v.expReq));
    checkOutput({tag, ".req_ack"},     32'(req_ack),     32'(v.expAck));
    checkOutput({tag, ".mem_id"},      32'(mem_id),      32'(v.expId));
    checkOutput({tag, ".mem_addr"},    32'(mem_addr),    32'(req_addr[id*30 +: 30]));
    checkOutput({tag, ".mem_rlen"},    32'(mem_rlen),    32'(req_rlen[id*5 +: 5]));
    checkOutput({tag, ".mem_rnw"},     32'(mem_rnw),     32'(req_rnw[id]));
    checkOutput({tag, ".mem_wbe"},     32'(mem_wbe),     32'(req_wbe[id*4 +: 4]));
    checkOutput({tag, ".mem_wdata"},   mem_wdata,        req_wdata[id*32 +: 32]);
    tick();
  endtask

  task automatic setMode(input int p, input logic rnw, input logic [4:0] rlen);
    req_rnw[p]         = rnw;
    req_rlen[p*5 +: 5] = rlen;
  endtask

  task automatic pushResp(input logic [1:0] rid, input logic [31:0] data);
    resp_t r;
    r.mask = 4'b0001 << rid;
    r.data = data;
    mem_rvalid = 1'b1;
    mem_rid    = rid;
    mem_rdata  = data;
    sbQ.push_back(r);
  endtask

  task automatic pulseRvalid(input logic [1:0] rid, input logic [31:0] data);
    pushResp(rid, data);
    @(negedge clk);
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic doReset();
    rst         = 1'b1;
    req_request = 4'b0000;
    mem_ack     = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Response monitor: whenever the DUT signals read data, match it against
  // the oldest expected response.
  always @(negedge clk) begin
    if (|req_rvalid) begin
      if (sbQ.size() == 0) begin
        checkOutput("rvalid_unexpected", 32'(req_rvalid), 32'h0);
      end else begin
        sbHead = sbQ.pop_front();
        checkOutput("rvalid_mask", 32'(req_rvalid), 32'(sbHead.mask));
        checkOutput("rdata", req_rdata, sbHead.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    req_request = '0;
    req_rnw     = '0;
    req_rmw     = '0;
    mem_ack     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rid     = '0;
    mem_rdata   = '0;
    for (int p = 0; p < 4; p++) begin
      req_addr[p*30 +: 30]  = 30'h100 + 30'(p);
      req_rlen[p*5 +: 5]    = 5'(p + 1);
      req_wbe[p*4 +: 4]     = 4'(p + 1);
      req_wdata[p*32 +: 32] = 32'hA000_0000 + 32'(p);
    end

    // Arbitration vectors from reset (last grant = 3), all ports writing.
    tbl[0]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2};
    tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3};
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0};
    tbl[6]  = '{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3};
    tbl[7]  = '{4'b0110, 1'b0, 1'b1, 4'b0000, 2'd1};
    tbl[8]  = '{4'b0111, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[9]  = '{4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2};
    tbl[10] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0};

    @(negedge clk);
    checkOutput("reset.mem_request", 32'(mem_request), 32'h0);
    checkOutput("reset.req_ack", 32'(req_ack), 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      runVec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Lock: port 2 held without ack while port 1 (next in line) joins.
    runVec('{4'b0101, 1'b0, 1'b1, 4'b0000, 2'd2}, "lock0");
    runVec('{4'b0111, 1'b0, 1'b1, 4'b0000, 2'd2}, "lock1");
    runVec('{4'b0111, 1'b0, 1'b1, 4'b0000, 2'd2}, "lock2");
    runVec('{4'b0111, 1'b1, 1'b1, 4'b0100, 2'd2}, "lock3");
    runVec('{4'b1011, 1'b1, 1'b1, 4'b1000, 2'd3}, "lock4");
    runVec('{4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0}, "lock5");

    // Port 1 reads 8 words; each return is routed to port 1 only.
    setMode(1, 1'b1, 5'd7);
    runVec('{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1}, "rd1");
    req_request = 4'b0000;
    checkOutput("rd1.outstanding", 32'(dut.outstanding_q[1]), 32'd8);
    for (int k = 0; k < 8; k++) begin
      pulseRvalid(2'd1, 32'hD000_0000 + 32'(k * 3));
    end
    checkOutput("rd1.drained", 32'(dut.outstanding_q[1]), 32'd0);

    // Throttle: port 0 holds 28 words, a further 8 is refused until 4 return.
    setMode(0, 1'b1, 5'd27);
    runVec('{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0}, "thr_fill");
    checkOutput("thr.outstanding28", 32'(dut.outstanding_q[0]), 32'd28);
    setMode(0, 1'b1, 5'd7);
    setMode(3, 1'b0, 5'd4);
    runVec('{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3}, "thr_write3");
    runVec('{4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0}, "thr_blocked");
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulseRvalid(2'd0, 32'hC0DE_0000 + 32'(k));
    end
    runVec('{4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0}, "thr_still25");
    mem_ack = 1'b0;
    pulseRvalid(2'd0, 32'hC0DE_0003);
    runVec('{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0}, "thr_release");
    checkOutput("thr.outstanding32", 32'(dut.outstanding_q[0]), 32'd32);

    // Same-cycle accept and return on port 0: 5 -> 8.
    doReset();
    checkOutput("rst.outstanding0", 32'(dut.outstanding_q[0]), 32'd0);
    setMode(0, 1'b1, 5'd4);
    runVec('{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0}, "same_fill");
    checkOutput("same.outstanding5", 32'(dut.outstanding_q[0]), 32'd5);
    setMode(0, 1'b1, 5'd3);
    pushResp(2'd0, 32'h5A5A_0001);
    runVec('{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0}, "same_both");
    mem_rvalid = 1'b0;
    checkOutput("same.outstanding8", 32'(dut.outstanding_q[0]), 32'd8);

    // Reset while locked on port 2 with 6 words outstanding.
    setMode(0, 1'b0, 5'd0);
    setMode(1, 1'b0, 5'd0);
    setMode(3, 1'b0, 5'd0);
    setMode(2, 1'b1, 5'd5);
    runVec('{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2}, "rl_fill");
    checkOutput("rl.outstanding6", 32'(dut.outstanding_q[2]), 32'd6);
    runVec('{4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2}, "rl_lock");
    rst         = 1'b1;
    req_request = 4'b1111;
    mem_ack     = 1'b0;
    @(negedge clk);
    checkOutput("rl.held_before_reset", 32'(mem_id), 32'd2);
    tick();
    rst = 1'b0;
    checkOutput("rl.outstanding_cleared", 32'(dut.outstanding_q[2]), 32'd0);
    runVec('{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0}, "rl_after");

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
